// File: rtl/sdrc_arb_pkg.sv
// rtl/sdrc_arb_pkg.sv - shared types and constants for the SDRAM request arbiter
package sdrc_arb_pkg;

  localparam int NPORT        = 4;
  localparam int PORT_W       = 2;
  localparam int SDR_REQ_ID_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // Lowest set bit of a port vector; returns 0 when the vector is empty.
  function automatic logic [PORT_W-1:0] lowest_set(input logic [NPORT-1:0] v);
    logic [PORT_W-1:0] idx;
    idx = '0;
    for (int k = NPORT - 1; k >= 0; k--) begin
      if (v[k]) idx = PORT_W'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sdrc_rr_pick.sv
// rtl/sdrc_rr_pick.sv - combinational round-robin picker
// Returns the first set request at or above rr_ptr, wrapping past the top port.
module sdrc_rr_pick
  import sdrc_arb_pkg::*;
(
  input  logic [NPORT-1:0]  req_vec,
  input  logic [PORT_W-1:0] rr_ptr,
  output logic              valid,
  output logic [PORT_W-1:0] index
);

  logic [PORT_W-1:0] cand;

  always_comb begin
    valid = |req_vec;
    index = rr_ptr;
    cand  = rr_ptr;
    // Walk offsets from farthest to nearest so the nearest requester wins last.
    for (int k = NPORT - 1; k >= 0; k--) begin
      cand = rr_ptr + PORT_W'(k);
      if (req_vec[cand]) index = cand;
    end
  end

endmodule

// File: rtl/sdrc_req_arb.sv
// rtl/sdrc_req_arb.sv - 4-port SDRAM request arbiter with round-robin and aging
// A winner is registered in IDLE and held stable in HOLD until the generator acks.
module sdrc_req_arb #(
  parameter int NPORT  = 4,
  parameter int APP_AW = 26,
  parameter int APP_RW = 9
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NPORT-1:0]                       p_req,
  input  logic [NPORT*APP_AW-1:0]                p_addr,
  input  logic [NPORT*APP_RW-1:0]                p_len,
  input  logic [NPORT-1:0]                       p_wr_n,
  input  logic [NPORT-1:0]                       p_wrap,
  output logic [NPORT-1:0]                       p_ack,
  input  logic [3:0]                             cfg_age_limit,
  output logic                                   req,
  output logic [APP_AW-1:0]                      req_addr,
  output logic [APP_RW-1:0]                      req_len,
  output logic                                   req_wr_n,
  output logic                                   req_wrap,
  output logic [sdrc_arb_pkg::SDR_REQ_ID_W-1:0]  req_id,
  input  logic                                   req_ack,
  output logic [1:0]                             grant_port,
  output logic                                   arb_busy
);

  import sdrc_arb_pkg::*;

  arb_state_e               state_q, state_d;
  logic [PORT_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PORT_W-1:0]        grant_q, grant_d;
  logic [APP_AW-1:0]        addr_q, addr_d;
  logic [APP_RW-1:0]        len_q, len_d;
  logic                     wr_n_q, wr_n_d;
  logic                     wrap_q, wrap_d;
  logic [NPORT-1:0][3:0]    age_q, age_d;

  logic [NPORT-1:0]         aged;
  logic                     rr_valid;
  logic [PORT_W-1:0]        rr_index;
  logic [PORT_W-1:0]        win;

  sdrc_rr_pick u_rr_pick (
    .req_vec (p_req),
    .rr_ptr  (rr_ptr_q),
    .valid   (rr_valid),
    .index   (rr_index)
  );

  // Qualified by p_req so a port dropping its request this cycle cannot win on a stale count.
  always_comb begin
    aged = '0;
    for (int i = 0; i < NPORT; i++) begin
      aged[i] = p_req[i] && (cfg_age_limit != 4'd0) && (age_q[i] >= cfg_age_limit);
    end
    win = (|aged) ? lowest_set(aged) : rr_index;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    len_d    = len_q;
    wr_n_d   = wr_n_q;
    wrap_d   = wrap_q;
    p_ack    = '0;
    case (state_q)
      IDLE: begin
        if (rr_valid) begin
          state_d = HOLD;
          grant_d = win;
          addr_d  = p_addr[win*APP_AW +: APP_AW];
          len_d   = p_len[win*APP_RW +: APP_RW];
          wr_n_d  = p_wr_n[win];
          wrap_d  = p_wrap[win];
        end
      end
      HOLD: begin
        if (req_ack) begin
          p_ack[grant_q] = 1'b1;
          state_d        = IDLE;
          rr_ptr_d       = grant_q + PORT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) p_ack = '0;
  end

  always_comb begin
    age_d = age_q;
    for (int i = 0; i < NPORT; i++) begin
      if (!p_req[i] || p_ack[i]) begin
        age_d[i] = 4'd0;
      end else if (!(state_q == HOLD && grant_q == PORT_W'(i)) && age_q[i] != 4'd15) begin
        age_d[i] = age_q[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      wr_n_q   <= 1'b0;
      wrap_q   <= 1'b0;
      age_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      wr_n_q   <= wr_n_d;
      wrap_q   <= wrap_d;
      age_q    <= age_d;
    end
  end

  assign req        = (state_q == HOLD);
  assign arb_busy   = (state_q == HOLD);
  assign req_addr   = addr_q;
  assign req_len    = len_q;
  assign req_wr_n   = wr_n_q;
  assign req_wrap   = wrap_q;
  assign req_id     = SDR_REQ_ID_W'(grant_q);
  assign grant_port = grant_q;

endmodule

// File: tb/tb_sdrc_req_arb.sv
// tb/tb_sdrc_req_arb.sv - scoreboard bench for the SDRAM request arbiter
module tb_sdrc_req_arb;

  localparam int NP = 4;
  localparam int AW = 26;
  localparam int RW = 9;

  typedef struct {
    int           id;
    logic [AW-1:0] addr;
    logic [RW-1:0] len;
    logic          wr_n;
    logic          wrap;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [NP-1:0]   p_req;
  logic [NP*AW-1:0] p_addr;
  logic [NP*RW-1:0] p_len;
  logic [NP-1:0]   p_wr_n;
  logic [NP-1:0]   p_wrap;
  logic [NP-1:0]   p_ack;
  logic [3:0]      cfg_age_limit;
  logic            req;
  logic [AW-1:0]   req_addr;
  logic [RW-1:0]   req_len;
  logic            req_wr_n;
  logic            req_wrap;
  logic [3:0]      req_id;
  logic            req_ack;
  logic [1:0]      grant_port;
  logic            arb_busy;

  logic [AW-1:0] pa [NP];
  logic [RW-1:0] pl [NP];
  exp_t          sb [$];
  exp_t          cur;
  int            n_chk = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  sdrc_req_arb #(.NPORT(NP), .APP_AW(AW), .APP_RW(RW)) dut (
    .clk           (clk),
    .reset         (reset),
    .p_req         (p_req),
    .p_addr        (p_addr),
    .p_len         (p_len),
    .p_wr_n        (p_wr_n),
    .p_wrap        (p_wrap),
    .p_ack         (p_ack),
    .cfg_age_limit (cfg_age_limit),
    .req           (req),
    .req_addr      (req_addr),
    .req_len       (req_len),
    .req_wr_n      (req_wr_n),
    .req_wrap      (req_wrap),
    .req_id        (req_id),
    .req_ack       (req_ack),
    .grant_port    (grant_port),
    .arb_busy      (arb_busy)
  );

  initial begin
    pa[0] = 26'h0000100; pl[0] = 9'd1;
    pa[1] = 26'h0001234; pl[1] = 9'd8;
    pa[2] = 26'h2abcdef; pl[2] = 9'd256;
    pa[3] = 26'h3ffffff; pl[3] = 9'd511;
    p_wr_n = 4'b0101;
    p_wrap = 4'b1010;
  end

  always_comb begin
    p_addr = '0;
    p_len  = '0;
    for (int i = 0; i < NP; i++) begin
      p_addr[i*AW +: AW] = pa[i];
      p_len[i*RW +: RW]  = pl[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int id);
    exp_t e;
    e.id   = id;
    e.addr = pa[id];
    e.len  = pl[id];
    e.wr_n = p_wr_n[id];
    e.wrap = p_wrap[id];
    sb.push_back(e);
  endtask

  task automatic wait_grant(input int exp_lat);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req && n < 20);
    chk("req_seen", 32'(req), 32'd1);
    chk("latency", n, exp_lat);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      cur = sb.pop_front();
      chk("req_id", 32'(req_id), cur.id);
      chk("grant_port", 32'(grant_port), cur.id);
      chk("req_addr", 32'(req_addr), 32'(cur.addr));
      chk("req_len", 32'(req_len), 32'(cur.len));
      chk("req_wr_n", 32'(req_wr_n), 32'(cur.wr_n));
      chk("req_wrap", 32'(req_wrap), 32'(cur.wrap));
      chk("arb_busy", 32'(arb_busy), 32'd1);
    end
  endtask

  task automatic finish_grant(input int ack_delay, input logic [NP-1:0] drop, input logic [NP-1:0] rel);
    p_req = p_req & ~drop;
    repeat (ack_delay) begin
      @(negedge clk);
      chk("hold_req", 32'(req), 32'd1);
      chk("hold_addr", 32'(req_addr), 32'(cur.addr));
      chk("hold_id", 32'(req_id), cur.id);
      chk("hold_pack", 32'(p_ack), 32'd0);
    end
    req_ack = 1'b1;
    #1;
    chk("p_ack", 32'(p_ack), 32'(1) << cur.id);
    @(negedge clk);
    req_ack = 1'b0;
    chk("idle_req", 32'(req), 32'd0);
    chk("idle_pack", 32'(p_ack), 32'd0);
    p_req = p_req & ~rel;
  endtask

  initial begin
    reset = 1'b1;
    p_req = '0;
    req_ack = 1'b0;
    cfg_age_limit = 4'd0;
    repeat (3) @(negedge clk);
    req_ack = 1'b1;
    #1;
    chk("rst_pack", 32'(p_ack), 32'd0);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_id", 32'(req_id), 32'd0);
    chk("rst_addr", 32'(req_addr), 32'd0);
    chk("rst_grant", 32'(grant_port), 32'd0);
    chk("rst_busy", 32'(arb_busy), 32'd0);
    reset = 1'b0;

    // Spurious ack in IDLE
    repeat (3) begin
      @(negedge clk);
      chk("spur_pack", 32'(p_ack), 32'd0);
      chk("spur_busy", 32'(arb_busy), 32'd0);
    end
    req_ack = 1'b0;

    // Round-robin with immediate acks: 0,1,2,3,0
    p_req = 4'hf;
    for (int k = 0; k < 5; k++) begin
      push(k % 4);
      wait_grant(1);
      finish_grant(0, 4'h0, (k == 4) ? 4'hf : 4'h0);
    end

    // Committed request survives p_req drop
    p_req = 4'b0100;
    push(2);
    wait_grant(1);
    finish_grant(3, 4'b0100, 4'h0);

    // Single port
    p_req = 4'b0010;
    push(1);
    wait_grant(1);
    finish_grant(3, 4'h0, 4'b0010);

    // Aging: aged port 0 beats rr choice 3, then aged 3 follows
    cfg_age_limit = 4'd4;
    p_req = 4'b1101;
    push(2);
    wait_grant(1);
    finish_grant(5, 4'h0, 4'b0100);
    push(0);
    wait_grant(1);
    finish_grant(5, 4'h0, 4'h0);
    push(3);
    wait_grant(1);
    finish_grant(0, 4'h0, 4'hf);
    cfg_age_limit = 4'd0;

    // Reset mid-HOLD with rr_ptr moved off zero first
    p_req = 4'b0010;
    push(1);
    wait_grant(1);
    finish_grant(0, 4'h0, 4'b0010);
    p_req = 4'b0100;
    push(2);
    wait_grant(1);
    @(negedge clk);
    reset = 1'b1;
    req_ack = 1'b1;
    p_req = 4'b0101;
    #1;
    chk("rst_hold_pack", 32'(p_ack), 32'd0);
    @(negedge clk);
    chk("rst_hold_req", 32'(req), 32'd0);
    chk("rst_hold_grant", 32'(grant_port), 32'd0);
    chk("rst_hold_busy", 32'(arb_busy), 32'd0);
    chk("rst_hold_pack2", 32'(p_ack), 32'd0);
    reset = 1'b0;
    req_ack = 1'b0;
    push(0);
    wait_grant(1);
    finish_grant(0, 4'h0, 4'b0101);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
